// File: rtl/sib_pkg.sv
// Shared coefficient encodings, FSM state type and default sizes for the
// SampleInBall shuffle controller.
package sib_pkg;

   localparam int SIB_N          = 256;
   localparam int SIB_TAU        = 60;
   localparam int SIB_SIGN_BYTES = 8;

   localparam logic [1:0] COEFF_ZERO = 2'b00;
   localparam logic [1:0] COEFF_POS  = 2'b01;
   localparam logic [1:0] COEFF_NEG  = 2'b11;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      SIGN,
      SAMPLE,
      READ,
      WRITE,
      DONE
   } sib_state_e;

endpackage

// File: rtl/sib_shuffle_ctrl.sv
// SampleInBall shuffle controller: consumes sign bytes then candidate j bytes
// and drives the two-port coefficient memory. SIB_REJECT_CNT_EN adds rej_cnt_o.
module sib_shuffle_ctrl
   import sib_pkg::*;
#(
   parameter int N          = SIB_N,
   parameter int TAU        = SIB_TAU,
   parameter int ADDR_WIDTH = $clog2(N),
   parameter int DATA_WIDTH = 2,
   parameter int SIGN_BYTES = SIB_SIGN_BYTES
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
   input  logic                                zeroize_i,
   input  logic                                start_i,
   input  logic                                byte_valid_i,
   input  logic [7:0]                          byte_i,
   output logic                                byte_ready_o,
   output logic                                mem_zeroize_o,
   output logic [1:0]                          mem_cs_o,
   output logic [1:0]                          mem_we_o,
   output logic [1:0][ADDR_WIDTH-1:0]          mem_addr_o,
   output logic [1:0][DATA_WIDTH-1:0]          mem_wdata_o,
   input  logic [1:0][DATA_WIDTH-1:0]          mem_rdata_i,
   output logic                                busy_o,
`ifdef SIB_REJECT_CNT_EN
   output logic [15:0]                         rej_cnt_o,
`endif
   output logic                                done_o
);

   localparam int SIGN_W = 8 * SIGN_BYTES;
   localparam int K_W    = $clog2(64);
   localparam int SC_W   = $clog2(SIGN_BYTES + 1);
   localparam int CMP_W  = (ADDR_WIDTH > 8) ? ADDR_WIDTH : 8;

   if (TAU > 64 || TAU > N) begin : g_tau_chk
      $error("sib_shuffle_ctrl: TAU must not exceed 64 or N");
   end

   sib_state_e            state_q, state_d;
   logic [SIGN_W-1:0]     sign_q, sign_d;
   logic [ADDR_WIDTH-1:0] i_q, i_d;
   logic [ADDR_WIDTH-1:0] j_q, j_d;
   logic [K_W-1:0]        k_q, k_d;
   logic [SC_W-1:0]       sc_q, sc_d;
   logic                  clr;
   logic                  accept;
   logic                  reject;
   logic                  unused_rdata0;

   assign clr           = rst_i | zeroize_i;
   // Never hand-shake a byte in a cycle whose state is about to be discarded.
   assign byte_ready_o  = ((state_q == SIGN) || (state_q == SAMPLE)) && !clr;
   assign accept        = byte_valid_i & byte_ready_o;
   assign reject        = accept && (state_q == SAMPLE) && (CMP_W'(byte_i) > CMP_W'(i_q));
   assign busy_o        = (state_q != IDLE);
   assign done_o        = (state_q == DONE);
   assign mem_zeroize_o = zeroize_i | (state_q == CLEAR);
   assign unused_rdata0 = ^mem_rdata_i[0];

   always_comb begin
      state_d = state_q;
      sign_d  = sign_q;
      i_d     = i_q;
      j_d     = j_q;
      k_d     = k_q;
      sc_d    = sc_q;
      unique case (state_q)
         IDLE: if (start_i) state_d = CLEAR;
         CLEAR: begin
            i_d     = ADDR_WIDTH'(N - TAU);
            k_d     = '0;
            sc_d    = '0;
            state_d = SIGN;
         end
         SIGN: if (accept) begin
            // Shift in from the top so byte 0 lands in bits [7:0].
            sign_d = {byte_i, sign_q[SIGN_W-1:8]};
            sc_d   = sc_q + 1'b1;
            if (sc_q == SC_W'(SIGN_BYTES - 1)) state_d = SAMPLE;
         end
         SAMPLE: if (accept && !reject) begin
            j_d     = ADDR_WIDTH'(byte_i);
            state_d = READ;
         end
         READ: state_d = WRITE;
         WRITE: begin
            k_d = k_q + 1'b1;
            if (i_q == ADDR_WIDTH'(N - 1)) begin
               state_d = DONE;
            end else begin
               i_d     = i_q + 1'b1;
               state_d = SAMPLE;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // When i==j both ports target one address; port 1 (sign value) wins in the memory.
   always_comb begin
      mem_cs_o    = '0;
      mem_we_o    = '0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      case (state_q)
         READ: begin
            mem_cs_o[1]   = 1'b1;
            mem_addr_o[1] = j_q;
         end
         WRITE: begin
            mem_cs_o       = 2'b11;
            mem_we_o       = 2'b11;
            mem_addr_o[0]  = i_q;
            mem_addr_o[1]  = j_q;
            mem_wdata_o[0] = mem_rdata_i[1];
            mem_wdata_o[1] = sign_q[k_q] ? DATA_WIDTH'(COEFF_NEG) : DATA_WIDTH'(COEFF_POS);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (clr) begin
         state_q <= IDLE;
         sign_q  <= '0;
         i_q     <= '0;
         j_q     <= '0;
         k_q     <= '0;
         sc_q    <= '0;
      end else begin
         state_q <= state_d;
         sign_q  <= sign_d;
         i_q     <= i_d;
         j_q     <= j_d;
         k_q     <= k_d;
         sc_q    <= sc_d;
      end
   end

`ifdef SIB_REJECT_CNT_EN
   logic [15:0] rej_cnt_q, rej_cnt_d;

   always_comb begin
      rej_cnt_d = rej_cnt_q;
      if (state_q == CLEAR) rej_cnt_d = '0;
      else if (reject && (rej_cnt_q != 16'hFFFF)) rej_cnt_d = rej_cnt_q + 16'd1;
   end

   always_ff @(posedge clk_i) begin
      if (clr) rej_cnt_q <= '0;
      else     rej_cnt_q <= rej_cnt_d;
   end

   assign rej_cnt_o = rej_cnt_q;
`endif

endmodule

// File: tb/tb_sib_shuffle_ctrl.sv
// Bench for sib_shuffle_ctrl: two-port memory model plus a SampleInBall
// reference computed directly from the byte stream.
module tb_sib_shuffle_ctrl;

   localparam int N    = 256;
   localparam int TAU  = 60;
   localparam int AW   = 8;
   localparam int DW   = 2;
   localparam int SB   = 8;
   localparam int MAXC = 4000;

   logic                clk_i = 1'b0;
   logic                rst_i, zeroize_i, start_i, byte_valid_i;
   logic [7:0]          byte_i;
   logic                byte_ready_o, mem_zeroize_o, busy_o, done_o;
   logic [1:0]          mem_cs_o, mem_we_o;
   logic [1:0][AW-1:0]  mem_addr_o;
   logic [1:0][DW-1:0]  mem_wdata_o, mem_rdata_i;
`ifdef SIB_REJECT_CNT_EN
   logic [15:0]         rej_cnt_o;
`endif

   always #5 clk_i = ~clk_i;

   sib_shuffle_ctrl #(.N(N), .TAU(TAU), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SIGN_BYTES(SB)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .zeroize_i(zeroize_i), .start_i(start_i),
      .byte_valid_i(byte_valid_i), .byte_i(byte_i), .byte_ready_o(byte_ready_o),
      .mem_zeroize_o(mem_zeroize_o), .mem_cs_o(mem_cs_o), .mem_we_o(mem_we_o),
      .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
      .busy_o(busy_o),
`ifdef SIB_REJECT_CNT_EN
      .rej_cnt_o(rej_cnt_o),
`endif
      .done_o(done_o)
   );

   // Two-port memory: registered reads, port 1 applied after port 0.
   logic [DW-1:0] mem [N];
   always @(posedge clk_i) begin
      if (mem_zeroize_o) begin
         for (int n = 0; n < N; n++) mem[n] <= '0;
      end else begin
         for (int p = 0; p < 2; p++) begin
            if (mem_cs_o[p]) begin
               if (mem_we_o[p]) mem[mem_addr_o[p]] <= mem_wdata_o[p];
               else             mem_rdata_i[p]     <= mem[mem_addr_o[p]];
            end
         end
      end
   end

   int            checks = 0;
   int            errors = 0;
   logic [7:0]    stream[$];
   logic [DW-1:0] exp_c [N];
   int            exp_rej, exp_used;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] pick(input int i, input int ex0, input int ex1, input int ex2);
      logic [7:0] v;
      do v = 8'($urandom_range(i, 0)); while (v == ex0 || v == ex1 || v == ex2);
      return v;
   endfunction

   task automatic gen_stream(input int rej_pct);
      stream.delete();
      for (int b = 0; b < SB; b++) stream.push_back(8'($urandom));
      for (int i = N - TAU; i < N; i++) begin
         while (i < N - 1 && $urandom_range(99) < rej_pct) stream.push_back(8'($urandom_range(255, i + 1)));
         stream.push_back(8'($urandom_range(i, 0)));
      end
   endtask

   // SampleInBall straight from its definition.
   task automatic model();
      logic [63:0] s;
      int p, k, j;
      s = '0;
      for (int n = 0; n < N; n++) exp_c[n] = '0;
      for (int b = 0; b < SB; b++) s[8*b +: 8] = stream[b];
      p = SB; k = 0; exp_rej = 0;
      for (int i = N - TAU; i < N; i++) begin
         j = int'(stream[p]); p++;
         while (j > i) begin exp_rej++; j = int'(stream[p]); p++; end
         exp_c[i] = exp_c[j];
         exp_c[j] = s[k] ? 2'b11 : 2'b01;
         k++;
      end
      exp_used = p;
   endtask

   task automatic check_mem(input string tag);
      int diff, nz;
      diff = 0; nz = 0;
      for (int n = 0; n < N; n++) begin
         if (mem[n] !== exp_c[n]) diff++;
         if (mem[n] !== 2'b00) nz++;
      end
      chk({tag, "_mem_vs_model"}, 64'(diff), 64'd0);
      chk({tag, "_nonzero_cnt"}, 64'(nz), 64'(TAU));
   endtask

   task automatic run(input string tag, input int gap_pct, input bit glitch, output int cyc);
      int idx, dn;
      bit acc;
      idx = 0; dn = 0; cyc = 0;
      start_i = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      while (dn == 0 && cyc < MAXC) begin
         byte_valid_i = (idx < stream.size()) && ($urandom_range(99) >= gap_pct);
         byte_i       = (idx < stream.size()) ? stream[idx] : 8'($urandom);
         start_i      = glitch && (cyc % 37 == 5);
         @(negedge clk_i);
         acc = byte_valid_i && byte_ready_o;
         @(posedge clk_i); #1;
         cyc++;
         if (acc) idx++;
         if (done_o) dn++;
      end
      byte_valid_i = 1'b0;
      start_i      = 1'b0;
      @(posedge clk_i); #1;
      if (done_o) dn++;
      chk({tag, "_done_pulses"}, 64'(dn), 64'd1);
      chk({tag, "_bytes_consumed"}, 64'(idx), 64'(exp_used));
      chk({tag, "_busy_after"}, 64'(busy_o), 64'd0);
      check_mem(tag);
   endtask

   task automatic abort(input string tag, input bit use_zero);
      int idx, n, nz;
      bit acc;
      idx = 0; n = 0; nz = 0;
      start_i = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      while (!(idx >= SB + 3 && byte_ready_o) && n < MAXC) begin
         byte_valid_i = 1'b1;
         byte_i       = stream[idx];
         @(negedge clk_i);
         acc = byte_valid_i && byte_ready_o;
         @(posedge clk_i); #1;
         n++;
         if (acc) idx++;
      end
      chk({tag, "_reached_sample"}, 64'(n < MAXC), 64'd1);
      if (use_zero) zeroize_i = 1'b1; else rst_i = 1'b1;
      #1;
      chk({tag, "_mem_zeroize_fwd"}, 64'(mem_zeroize_o), 64'(use_zero));
      @(posedge clk_i); #1;
      rst_i = 1'b0; zeroize_i = 1'b0; byte_valid_i = 1'b0;
      chk({tag, "_busy"}, 64'(busy_o), 64'd0);
      chk({tag, "_ready"}, 64'(byte_ready_o), 64'd0);
      chk({tag, "_cs"}, 64'(mem_cs_o), 64'd0);
      chk({tag, "_done"}, 64'(done_o), 64'd0);
      if (use_zero) begin
         for (int m = 0; m < N; m++) if (mem[m] !== 2'b00) nz++;
         chk({tag, "_mem_cleared"}, 64'(nz), 64'd0);
      end
`ifdef SIB_REJECT_CNT_EN
      chk({tag, "_rej_cnt"}, 64'(rej_cnt_o), 64'd0);
`endif
   endtask

   initial begin
      int cyc, diff;
      logic [DW-1:0] saved [N];
      rst_i = 1'b1; zeroize_i = 1'b0; start_i = 1'b0; byte_valid_i = 1'b0; byte_i = '0;
      repeat (3) @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      chk("reset_busy", 64'(busy_o), 64'd0);
      chk("reset_ready", 64'(byte_ready_o), 64'd0);
      chk("reset_cs", 64'(mem_cs_o), 64'd0);
      chk("reset_we", 64'(mem_we_o), 64'd0);
      chk("reset_done", 64'(done_o), 64'd0);
      chk("reset_mem_zeroize", 64'(mem_zeroize_o), 64'd0);

      // Random stream with no rejects and no gaps: minimum latency.
      gen_stream(0);
      model();
      run("nogap", 0, 1'b0, cyc);
      chk("min_run_cycles", 64'(cyc + 1), 64'(1 + SB + 3 * TAU + 1));
`ifdef SIB_REJECT_CNT_EN
      chk("nogap_rej_cnt", 64'(rej_cnt_o), 64'd0);
`endif

      gen_stream(30);
      abort("rst_mid", 1'b0);
      abort("zeroize_mid", 1'b1);

      // Directed: rejects at i=196 and an i==j step at i=200 (sign bit 4 set).
      stream.delete();
      stream.push_back(8'hFF);
      for (int b = 1; b < SB; b++) stream.push_back(8'($urandom));
      stream.push_back(8'hFF);
      stream.push_back(8'hC5);
      stream.push_back(8'h10);
      for (int i = 197; i < 200; i++) stream.push_back(pick(i, 16, 196, 200));
      stream.push_back(8'd200);
      for (int i = 201; i < N; i++) stream.push_back(pick(i, 16, 196, 200));
      model();
      run("directed", 0, 1'b0, cyc);
      chk("rej_j10_c16", 64'(mem[16]), 64'd3);
      chk("rej_c196_zero", 64'(mem[196]), 64'd0);
      chk("ij_c200_neg", 64'(mem[200]), 64'd3);
`ifdef SIB_REJECT_CNT_EN
      chk("directed_rej_cnt", 64'(rej_cnt_o), 64'd2);
`endif
      for (int n = 0; n < N; n++) saved[n] = mem[n];

      // Same stream with valid gaps and start_i pulses while busy.
      run("backpressure", 40, 1'b1, cyc);
      diff = 0;
      for (int n = 0; n < N; n++) if (mem[n] !== saved[n]) diff++;
      chk("backpressure_same_as_nogap", 64'(diff), 64'd0);
`ifdef SIB_REJECT_CNT_EN
      chk("backpressure_rej_cnt", 64'(rej_cnt_o), 64'd2);
`endif

      // Random stream with rejects and gaps.
      gen_stream(25);
      model();
      run("random_rej", 20, 1'b0, cyc);
`ifdef SIB_REJECT_CNT_EN
      chk("random_rej_cnt", 64'(rej_cnt_o), 64'(exp_rej));
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
